usb_rx_control: RTL and testbench
=================================

# usb_rx_control

Receive-side packet controller for the USB endpoint. It consumes the byte stream from the RX decoder, validates and classifies the PID, and checks each packet's length. Data-packet payload goes into the endpoint data buffer with the trailing CRC16 bytes stripped. The block reports packet type, data-ready and error status to the AHB-side interface. It mirrors the transmit-side control logic and shares the same 3-bit packet encoding and the same 7-bit buffer occupancy.

## Interface
- No parameters. Max payload is fixed at 64 bytes.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- rx_sop  in  1  one-cycle pulse, sync pattern detected
- rx_valid_byte  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  decoded byte, LSB first on wire
- rx_eop  in  1  one-cycle pulse, EOP detected
- rx_bit_error  in  1  one-cycle pulse, stuffing or decode error from the decoder
- buffer_occupancy  in  7  current data-buffer byte count, 0..64
- rx_packet  out  3  0 none, 1 OUT, 2 IN, 3 DATA0/DATA1, 4 ACK, 5 NAK
- rx_data_ready  out  1  one-cycle pulse, good data packet complete
- rx_transfer_active  out  1  packet reception in progress
- rx_error  out  1  sticky error flag
- store_rx_packet_data  out  1  one-cycle write strobe to buffer
- rx_packet_data  out  8  byte to write
- flush  out  1  one-cycle buffer clear at start of a DATA packet

## Operation
- States are IDLE, PID, TOKEN, DATA, HSHAKE, ERR.
  - IDLE: on rx_sop go to PID. Clear rx_error, set rx_packet=0, set rx_transfer_active=1.
  - PID: on the first byte, check rx_byte[7:4] == ~rx_byte[3:0].
    - Valid PIDs: 0001 OUT→TOKEN, 1001 IN→TOKEN, 0011/1011 DATA→DATA with flush pulse, 0010 ACK→HSHAKE, 1010 NAK→HSHAKE.
    - A bad complement or any other PID goes to ERR.
  - TOKEN: requires exactly 2 bytes, then rx_eop. rx_packet becomes 1 or 2 at EOP.
  - HSHAKE: requires rx_eop with zero further bytes. rx_packet becomes 4 or 5.
  - DATA: uses a 2-byte holdback register (h0 oldest, h1).
    - On each byte once h0 and h1 are both full, write h0 to the buffer, then shift.
    - At EOP, h0/h1 hold the CRC and are discarded.
    - Requires at least 2 bytes after the PID.
    - At a good EOP: rx_packet=3 and rx_data_ready pulses.
  - ERR: rx_error=1. Wait for rx_eop, then go to IDLE. rx_packet=0.
- Errors, each of which sets rx_error and routes to ERR (or directly to IDLE if the same cycle is an EOP):
  - rx_bit_error in any non-IDLE state.
  - rx_sop in any non-IDLE state.
  - Token byte count ≠ 2.
  - Handshake with any extra byte.
  - Fewer than 2 data bytes at EOP.
  - A write attempt when buffer_occupancy == 64 (the byte is dropped).
  - More than 64 payload bytes.
  - rx_eop in PID state.
- Every EOP returns the FSM to IDLE, and rx_transfer_active drops.
- rx_packet and rx_error hold their values until the next rx_sop.
- If rx_valid_byte and rx_eop arrive in the same cycle, the byte is processed first, then the EOP.
- An rx_sop coinciding with rx_eop in IDLE is ignored by the EOP logic; only the SOP is honoured.
- All outputs are registered.

## Timing
- Reset values: state IDLE; rx_packet=0; rx_data_ready=0; rx_transfer_active=0; rx_error=0; store_rx_packet_data=0; rx_packet_data=0; flush=0; holdback empty.
- rx_transfer_active rises the cycle after rx_sop and falls the cycle after rx_eop.
- flush is asserted the cycle after the DATA PID byte strobe.
- store_rx_packet_data is asserted one cycle after the byte strobe that causes the shift, with rx_packet_data = h0. There is at most one write per input byte.
- rx_packet, rx_data_ready and error status update the cycle after rx_eop.
- rx_error rises the cycle after the offending event.
- Reset mid-packet takes effect on the next edge, gives the reset values above, and suppresses any pending write or pulse.

## Test plan
- SOP, bytes 0xE1, 0x00, 0x00, EOP (OUT token): rx_packet=1, rx_error=0, no store, rx_transfer_active high for 4 cycles of gaps plus 1.
- SOP, 0xC3, 0x11, 0x22, 0x33, CRC 0xAA, 0xBB, EOP: flush once; exactly 3 stores of 0x11, 0x22, 0x33; rx_packet=3; rx_data_ready pulses once.
- SOP, 0xC4 (bad complement): rx_error=1 the next cycle; later bytes are ignored; FSM returns to IDLE at EOP.
- SOP, 0xD2, 0x55, EOP (ACK with an extra byte): rx_error=1, rx_packet=0.
- DATA packet with buffer_occupancy held at 64 during the payload: no stores, rx_error=1. Also a 66-byte payload: rx_error=1 on the 65th payload byte.
- rst asserted mid-DATA after 10 bytes: all outputs 0 the next cycle. A following clean OUT token decodes as rx_packet=1.

Source files
------------

// File: rtl/usb_rx_control.sv
// usb_rx_control: receive-side USB packet controller. Classifies the PID, checks
// packet length and streams DATA payload to the endpoint buffer with CRC16 stripped.
module usb_rx_control (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_sop,
  input  logic       rx_valid_byte,
  input  logic [7:0] rx_byte,
  input  logic       rx_eop,
  input  logic       rx_bit_error,
  input  logic [6:0] buffer_occupancy,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic       store_rx_packet_data,
  output logic [7:0] rx_packet_data,
  output logic       flush
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PID    = 3'd1,
    S_TOKEN  = 3'd2,
    S_DATA   = 3'd3,
    S_HSHAKE = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [2:0] PKT_NONE    = 3'd0;
  localparam logic [2:0] PKT_OUT     = 3'd1;
  localparam logic [2:0] PKT_IN      = 3'd2;
  localparam logic [2:0] PKT_DATA    = 3'd3;
  localparam logic [2:0] PKT_ACK     = 3'd4;
  localparam logic [2:0] PKT_NAK     = 3'd5;
  localparam logic [6:0] MAX_PAYLOAD = 7'd64;

  // Map a PID byte to its packet code; PKT_NONE for bad complement or unsupported PID.
  function automatic logic [2:0] pid_code(input logic [7:0] pid);
    logic [2:0] code;
    code = PKT_NONE;
    if (pid[7:4] == ~pid[3:0]) begin
      case (pid[3:0])
        4'b0001:          code = PKT_OUT;
        4'b1001:          code = PKT_IN;
        4'b0011, 4'b1011: code = PKT_DATA;
        4'b0010:          code = PKT_ACK;
        4'b1010:          code = PKT_NAK;
        default:          code = PKT_NONE;
      endcase
    end else begin
      code = PKT_NONE;
    end
    return code;
  endfunction

  state_t     state_q, state_d, st_b;
  logic [2:0] packet_q, packet_d;
  logic       ready_q, ready_d;
  logic       active_q, active_d;
  logic       error_q, error_d;
  logic       store_q, store_d;
  logic [7:0] pdata_q, pdata_d;
  logic       flush_q, flush_d;
  logic [7:0] h0_q, h0_d, h1_q, h1_d;
  logic [1:0] hcnt_q, hcnt_d;
  logic [6:0] wr_cnt_q, wr_cnt_d;
  logic [1:0] tok_cnt_q, tok_cnt_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] pid_code_s;
  logic       bad_b;

  assign rx_packet            = packet_q;
  assign rx_data_ready        = ready_q;
  assign rx_transfer_active   = active_q;
  assign rx_error             = error_q;
  assign store_rx_packet_data = store_q;
  assign rx_packet_data       = pdata_q;
  assign flush                = flush_q;

  // Next-state logic: the byte of a cycle is applied first (st_b), then any EOP.
  always_comb begin
    state_d    = state_q;
    packet_d   = packet_q;
    ready_d    = 1'b0;
    active_d   = active_q;
    error_d    = error_q;
    store_d    = 1'b0;
    pdata_d    = pdata_q;
    flush_d    = 1'b0;
    h0_d       = h0_q;
    h1_d       = h1_q;
    hcnt_d     = hcnt_q;
    wr_cnt_d   = wr_cnt_q;
    tok_cnt_d  = tok_cnt_q;
    pend_d     = pend_q;
    st_b       = state_q;
    bad_b      = 1'b0;
    pid_code_s = pid_code(rx_byte);

    if (state_q == S_IDLE) begin
      if (rx_sop) begin
        state_d   = S_PID;
        error_d   = 1'b0;
        packet_d  = PKT_NONE;
        hcnt_d    = 2'd0;
        wr_cnt_d  = 7'd0;
        tok_cnt_d = 2'd0;
        pend_d    = PKT_NONE;
      end else begin
        state_d = S_IDLE;
      end
    end else if (rx_bit_error || rx_sop) begin
      error_d = 1'b1;
      state_d = rx_eop ? S_IDLE : S_ERR;
    end else begin
      if (rx_valid_byte) begin
        case (state_q)
          S_PID: begin
            pend_d = pid_code_s;
            case (pid_code_s)
              PKT_OUT, PKT_IN: st_b = S_TOKEN;
              PKT_DATA: begin
                st_b    = S_DATA;
                flush_d = 1'b1;
              end
              PKT_ACK, PKT_NAK: st_b = S_HSHAKE;
              default: bad_b = 1'b1;
            endcase
          end
          S_TOKEN: begin
            if (tok_cnt_q == 2'd2) begin
              bad_b = 1'b1;
            end else begin
              tok_cnt_d = tok_cnt_q + 2'd1;
            end
          end
          S_HSHAKE: bad_b = 1'b1;
          S_DATA: begin
            // Two-byte holdback keeps the CRC16 out of the buffer.
            case (hcnt_q)
              2'd0: begin
                h0_d   = rx_byte;
                hcnt_d = 2'd1;
              end
              2'd1: begin
                h1_d   = rx_byte;
                hcnt_d = 2'd2;
              end
              default: begin
                if ((wr_cnt_q == MAX_PAYLOAD) || (buffer_occupancy >= MAX_PAYLOAD)) begin
                  bad_b = 1'b1;
                end else begin
                  store_d  = 1'b1;
                  pdata_d  = h0_q;
                  h0_d     = h1_q;
                  h1_d     = rx_byte;
                  wr_cnt_d = wr_cnt_q + 7'd1;
                end
              end
            endcase
          end
          default: st_b = state_q;
        endcase
      end else begin
        st_b = state_q;
      end

      if (bad_b) begin
        error_d = 1'b1;
        st_b    = S_ERR;
      end else begin
        error_d = error_q;
      end

      if (rx_eop) begin
        state_d = S_IDLE;
        case (st_b)
          S_TOKEN: begin
            if (tok_cnt_d == 2'd2) begin
              packet_d = pend_d;
            end else begin
              error_d = 1'b1;
            end
          end
          S_HSHAKE: packet_d = pend_d;
          S_DATA: begin
            if (hcnt_d == 2'd2) begin
              packet_d = PKT_DATA;
              ready_d  = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
          S_PID:   error_d  = 1'b1;
          default: packet_d = packet_q;
        endcase
      end else begin
        state_d = st_b;
      end
    end

    active_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      packet_q  <= PKT_NONE;
      ready_q   <= 1'b0;
      active_q  <= 1'b0;
      error_q   <= 1'b0;
      store_q   <= 1'b0;
      pdata_q   <= 8'd0;
      flush_q   <= 1'b0;
      h0_q      <= 8'd0;
      h1_q      <= 8'd0;
      hcnt_q    <= 2'd0;
      wr_cnt_q  <= 7'd0;
      tok_cnt_q <= 2'd0;
      pend_q    <= PKT_NONE;
    end else begin
      state_q   <= state_d;
      packet_q  <= packet_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
      error_q   <= error_d;
      store_q   <= store_d;
      pdata_q   <= pdata_d;
      flush_q   <= flush_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      hcnt_q    <= hcnt_d;
      wr_cnt_q  <= wr_cnt_d;
      tok_cnt_q <= tok_cnt_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: tb/tb_usb_rx_control.sv
// Self-checking bench for usb_rx_control: packet-level queue model compared every
// cycle, plus hand-computed literal expectations per directed packet.
module tb_usb_rx_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_sop;
  logic       rx_valid_byte;
  logic [7:0] rx_byte;
  logic       rx_eop;
  logic       rx_bit_error;
  logic [6:0] buffer_occupancy;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       flush;

  always #5 clk = ~clk;

  usb_rx_control dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx_sop               (rx_sop),
    .rx_valid_byte        (rx_valid_byte),
    .rx_byte              (rx_byte),
    .rx_eop               (rx_eop),
    .rx_bit_error         (rx_bit_error),
    .buffer_occupancy     (buffer_occupancy),
    .rx_packet            (rx_packet),
    .rx_data_ready        (rx_data_ready),
    .rx_transfer_active   (rx_transfer_active),
    .rx_error             (rx_error),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .flush                (flush)
  );

  int tests = 0;
  int fails = 0;

  // Expected outputs from the model
  logic [2:0] e_pkt;
  logic       e_ready, e_act, e_err, e_store, e_flush;
  logic [7:0] e_data;
  bit         m_on = 1'b0;
  bit         m_busy, m_dead;
  logic [2:0] m_kind;
  logic [7:0] q[$];

  // Observation counters
  int         n_store, n_flush, n_ready, n_active;
  logic [7:0] cap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] classify(input logic [7:0] pid);
    case (pid)
      8'hE1:        return 3'd1;
      8'h69:        return 3'd2;
      8'hC3, 8'h4B: return 3'd3;
      8'hD2:        return 3'd4;
      8'h5A:        return 3'd5;
      default:      return 3'd0;
    endcase
  endfunction

  // Packet-level model: q holds every byte since SOP (q[0] is the PID).
  always @(posedge clk) begin : model
    int n;
    if (rst) begin
      m_on = 1'b1; m_busy = 1'b0; m_dead = 1'b0; q.delete();
      e_pkt = 3'd0; e_ready = 1'b0; e_act = 1'b0; e_err = 1'b0;
      e_store = 1'b0; e_data = 8'd0; e_flush = 1'b0;
    end else begin
      e_store = 1'b0; e_flush = 1'b0; e_ready = 1'b0;
      if (!m_busy) begin
        if (rx_sop) begin
          m_busy = 1'b1; m_dead = 1'b0; q.delete();
          e_err = 1'b0; e_pkt = 3'd0; e_act = 1'b1;
        end
      end else begin
        if (rx_bit_error || rx_sop) begin
          m_dead = 1'b1; e_err = 1'b1;
        end else if (rx_valid_byte && !m_dead) begin
          q.push_back(rx_byte);
          n = q.size();
          if (n == 1) begin
            m_kind = classify(rx_byte);
            if (m_kind == 3'd0) begin m_dead = 1'b1; e_err = 1'b1; end
            if (m_kind == 3'd3) e_flush = 1'b1;
          end else if (m_kind == 3'd3) begin
            // Byte n pushes out payload byte n-3 (two newest are possible CRC).
            if (n >= 4) begin
              if ((n - 3 > 64) || (buffer_occupancy == 7'd64)) begin
                m_dead = 1'b1; e_err = 1'b1;
              end else begin
                e_store = 1'b1; e_data = q[n-3];
              end
            end
          end else if ((m_kind == 3'd1 || m_kind == 3'd2) && n > 3) begin
            m_dead = 1'b1; e_err = 1'b1;
          end else if (m_kind == 3'd4 || m_kind == 3'd5) begin
            m_dead = 1'b1; e_err = 1'b1;
          end
        end
        if (rx_eop) begin
          m_busy = 1'b0; e_act = 1'b0;
          if (!m_dead) begin
            n = q.size();
            if (n == 0) e_err = 1'b1;
            else if (m_kind == 3'd1 || m_kind == 3'd2) begin
              if (n == 3) e_pkt = m_kind; else e_err = 1'b1;
            end else if (m_kind == 3'd4 || m_kind == 3'd5) begin
              e_pkt = m_kind;
            end else if (n >= 3) begin
              e_pkt = 3'd3; e_ready = 1'b1;
            end else e_err = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare against the model and event counting
  always @(negedge clk) begin
    if (m_on) begin
      check("cyc_rx_packet", {29'd0, rx_packet}, {29'd0, e_pkt});
      check("cyc_data_ready", {31'd0, rx_data_ready}, {31'd0, e_ready});
      check("cyc_active", {31'd0, rx_transfer_active}, {31'd0, e_act});
      check("cyc_rx_error", {31'd0, rx_error}, {31'd0, e_err});
      check("cyc_store", {31'd0, store_rx_packet_data}, {31'd0, e_store});
      check("cyc_pdata", {24'd0, rx_packet_data}, {24'd0, e_data});
      check("cyc_flush", {31'd0, flush}, {31'd0, e_flush});
      if (store_rx_packet_data === 1'b1) begin n_store++; cap.push_back(rx_packet_data); end
      if (flush === 1'b1) n_flush++;
      if (rx_data_ready === 1'b1) n_ready++;
      if (rx_transfer_active === 1'b1) n_active++;
    end
  end

  task automatic step(input logic s, input logic v, input logic [7:0] b, input logic e, input logic be);
    rx_sop = s; rx_valid_byte = v; rx_byte = b; rx_eop = e; rx_bit_error = be;
    @(posedge clk); #1;
    rx_sop = 1'b0; rx_valid_byte = 1'b0; rx_eop = 1'b0; rx_bit_error = 1'b0;
  endtask

  task automatic do_sop();                      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0); endtask
  task automatic do_byte(input logic [7:0] b);  step(1'b0, 1'b1, b, 1'b0, 1'b0);     endtask
  task automatic do_eop();                      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0); endtask
  task automatic do_idle();                     step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0); endtask

  task automatic clear_counts();
    n_store = 0; n_flush = 0; n_ready = 0; n_active = 0; cap.delete();
  endtask

  initial begin
    rst = 1'b1; rx_sop = 1'b0; rx_valid_byte = 1'b0; rx_byte = 8'h00;
    rx_eop = 1'b0; rx_bit_error = 1'b0; buffer_occupancy = 7'd0;
    clear_counts();
    @(posedge clk); #1; @(posedge clk); #1;
    check("reset_outputs", {16'd0, rx_packet, rx_data_ready, rx_transfer_active, rx_error,
          store_rx_packet_data, rx_packet_data, flush}, 32'd0);
    rst = 1'b0;
    do_idle();

    // OUT token
    clear_counts();
    do_sop(); do_byte(8'hE1); do_byte(8'h00); do_byte(8'h00); do_eop();
    check("out_pkt", {29'd0, rx_packet}, 32'd1);
    check("out_err", {31'd0, rx_error}, 32'd0);
    do_idle();
    check("out_stores", n_store, 0);
    check("out_active_cycles", n_active, 4);

    // DATA0 with 3 payload bytes + CRC
    clear_counts();
    do_sop(); do_byte(8'hC3); do_byte(8'h11); do_byte(8'h22); do_byte(8'h33);
    do_byte(8'hAA); do_byte(8'hBB); do_eop(); do_idle();
    check("data_flush", n_flush, 1);
    check("data_stores", n_store, 3);
    if (cap.size() == 3) check("data_bytes", {8'd0, cap[0], cap[1], cap[2]}, 32'h00112233);
    check("data_pkt", {29'd0, rx_packet}, 32'd3);
    check("data_ready", n_ready, 1);
    check("data_err", {31'd0, rx_error}, 32'd0);

    // Bad PID complement
    do_sop(); do_byte(8'hC4);
    check("badpid_err", {31'd0, rx_error}, 32'd1);
    do_byte(8'h00); do_byte(8'h00);
    check("badpid_active", {31'd0, rx_transfer_active}, 32'd1);
    do_eop();
    check("badpid_idle", {31'd0, rx_transfer_active}, 32'd0);
    check("badpid_pkt", {29'd0, rx_packet}, 32'd0);

    // ACK with an extra byte, then clean ACK with byte+EOP together
    do_sop(); do_byte(8'hD2); do_byte(8'h55); do_eop();
    check("ackx_err", {31'd0, rx_error}, 32'd1);
    check("ackx_pkt", {29'd0, rx_packet}, 32'd0);
    do_sop(); step(1'b0, 1'b1, 8'hD2, 1'b1, 1'b0);
    check("ack_pkt", {29'd0, rx_packet}, 32'd4);
    check("ack_err", {31'd0, rx_error}, 32'd0);

    // NAK, IN token, DATA1 with CRC only
    do_sop(); do_byte(8'h5A); do_eop();
    check("nak_pkt", {29'd0, rx_packet}, 32'd5);
    do_sop(); do_byte(8'h69); do_byte(8'hAB); do_byte(8'hCD); do_eop();
    check("in_pkt", {29'd0, rx_packet}, 32'd2);
    clear_counts();
    do_sop(); do_byte(8'h4B); do_byte(8'h01); do_byte(8'h02); do_eop(); do_idle();
    check("data1_pkt", {29'd0, rx_packet}, 32'd3);
    check("data1_stores", n_store, 0);
    check("data1_ready", n_ready, 1);

    // Short DATA, long token, EOP in PID, bit error, SOP inside a packet
    do_sop(); do_byte(8'hC3); do_byte(8'hAA); do_eop();
    check("short_err", {31'd0, rx_error}, 32'd1);
    check("short_pkt", {29'd0, rx_packet}, 32'd0);
    do_sop(); do_byte(8'hE1); do_byte(8'h00); do_byte(8'h00); do_byte(8'h00);
    check("tok3_err", {31'd0, rx_error}, 32'd1);
    do_eop();
    do_sop(); do_eop();
    check("pid_eop_err", {31'd0, rx_error}, 32'd1);
    do_sop(); do_byte(8'hE1); step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("biterr_err", {31'd0, rx_error}, 32'd1);
    do_eop();
    do_sop(); do_byte(8'h69); do_sop();
    check("sop_in_pkt_err", {31'd0, rx_error}, 32'd1);
    do_eop();
    step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    check("idle_sop_eop_active", {31'd0, rx_transfer_active}, 32'd1);
    check("idle_sop_eop_err", {31'd0, rx_error}, 32'd0);
    do_byte(8'h5A); do_eop();
    check("idle_sop_eop_nak", {29'd0, rx_packet}, 32'd5);

    // Buffer full during payload
    clear_counts();
    do_sop(); do_byte(8'hC3);
    buffer_occupancy = 7'd64;
    do_byte(8'h01); do_byte(8'h02); do_byte(8'h03);
    check("full_err", {31'd0, rx_error}, 32'd1);
    do_byte(8'h04); do_eop();
    buffer_occupancy = 7'd0;
    do_idle();
    check("full_stores", n_store, 0);
    check("full_pkt", {29'd0, rx_packet}, 32'd0);

    // 66-byte payload: overflow detected on the byte that pushes payload byte 65
    clear_counts();
    do_sop(); do_byte(8'hC3);
    for (int i = 1; i <= 68; i++) begin
      do_byte(i[7:0]);
      if (i == 66) check("long_err_before", {31'd0, rx_error}, 32'd0);
      if (i == 67) check("long_err_at", {31'd0, rx_error}, 32'd1);
    end
    do_eop(); do_idle();
    check("long_stores", n_store, 64);
    if (cap.size() > 0) check("long_last_byte", {24'd0, cap[cap.size()-1]}, 32'h40);
    check("long_ready", n_ready, 0);

    // Reset mid-DATA with a write pending
    do_sop(); do_byte(8'hC3);
    for (int i = 0; i < 9; i++) do_byte(8'h80 + i[7:0]);
    rst = 1'b1; rx_valid_byte = 1'b1; rx_byte = 8'h77;
    @(posedge clk); #1;
    check("midrst_outputs", {16'd0, rx_packet, rx_data_ready, rx_transfer_active, rx_error,
          store_rx_packet_data, rx_packet_data, flush}, 32'd0);
    rst = 1'b0; rx_valid_byte = 1'b0;
    do_idle();
    do_sop(); do_byte(8'hE1); do_byte(8'h00); do_byte(8'h00); do_eop();
    check("post_rst_out", {29'd0, rx_packet}, 32'd1);
    do_idle(); do_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
